i2c_slave_oe: RTL and testbench

I2C target (responder) with the same split-line, open-drain pin interface as the team's i2c_master_oe. It lets the sensor-polling FSM/FIFO path run against an on-chip device model instead of a real sensor. The block holds a small register file. The master writes a register pointer and data bytes, and reads bytes back with pointer auto-increment. Register 0 is read-only and is loaded from a local sensor-data stream.

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_slave_oe_if.sv | 34 +++
 rtl/i2c_line_sync.sv | 59 +++++
 rtl/i2c_slave_oe.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_slave_oe.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, ACK/NAK line levels,
// synchronizer depth and the register-write event payload.
package i2c_pkg;

    localparam int unsigned SYNC_DEPTH = 2;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_ADDR_W = 4;

    localparam logic ACK = 1'b0;
    localparam logic NAK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } state_e;

    // One master-written byte as reported on the write-event port
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     bits;
    } wr_evt_t;

endpackage

// File: rtl/i2c_slave_oe_if.sv
// Pin and side-band bundle of the I2C target.
//   i_sda_in/i_scl_in : pad inputs
//   o_sda_oe/o_sda_out: open-drain SDA drive (oe=1 pulls low, out tied 0)
//   i_sensor_*        : register 0 load stream, o_sensor_ready its ready
//   o_wr_*            : per-byte report of master writes
//   o_busy            : device currently addressed
interface i2c_slave_oe_if;
    import i2c_pkg::*;

    logic                  i_sda_in;
    logic                  i_scl_in;
    logic                  o_sda_oe;
    logic                  o_sda_out;
    logic [DATA_W-1:0]     i_sensor_bits;
    logic                  i_sensor_valid;
    logic                  o_sensor_ready;
    logic [REG_ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0]     o_wr_bits;
    logic                  o_wr_valid;
    logic                  o_busy;

    modport slave (
        input  i_sda_in, i_scl_in, i_sensor_bits, i_sensor_valid,
        output o_sda_oe, o_sda_out, o_sensor_ready,
               o_wr_addr, o_wr_bits, o_wr_valid, o_busy
    );

    modport master (
        output i_sda_in, i_scl_in, i_sensor_bits, i_sensor_valid,
        input  o_sda_oe, o_sda_out, o_sensor_ready,
               o_wr_addr, o_wr_bits, o_wr_valid, o_busy
    );

endinterface

// File: rtl/i2c_line_sync.sv
// SDA/SCL synchronizer with edge and START/STOP detection.
//   clk, rst_n       : system clock, async active-low reset
//   scl_in, sda_in   : raw pad inputs
//   scl_rise/scl_fall: one-cycle strobes on synchronized SCL edges
//   sda_sync         : synchronized SDA level
//   start_det/stop_det: SDA fall/rise while SCL is held high
// Edge strobes are decoded straight from the flop outputs so that the
// consumer can react one cycle after the synchronizer settles.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_sync,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_DEPTH-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_DEPTH-1:0] sda_sync_q, sda_sync_d;
    logic                  scl_dly_q, scl_dly_d;
    logic                  sda_dly_q, sda_dly_d;
    logic                  scl_s;

    // Shift chains plus one delayed copy for edge compare
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_DEPTH-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_DEPTH-2:0], sda_in};
        scl_dly_d  = scl_sync_q[SYNC_DEPTH-1];
        sda_dly_d  = sda_sync_q[SYNC_DEPTH-1];
    end

    // Reset to the idle bus level so release does not look like an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_dly_q  <= scl_dly_d;
            sda_dly_q  <= sda_dly_d;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_DEPTH-1];
    assign sda_sync  = sda_sync_q[SYNC_DEPTH-1];
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    assign start_det = scl_s & scl_dly_q & ~sda_sync & sda_dly_q;
    assign stop_det  = scl_s & scl_dly_q & sda_sync & ~sda_dly_q;

endmodule

// File: rtl/i2c_slave_oe.sv
// I2C target with a small register file and open-drain SDA drive.
//   i_clk, i_rst : system clock, async active-low reset
//   bus          : pins, sensor load stream, write reports, busy flag
// Master writes a pointer then data bytes (pointer auto-increments);
// reads return bytes from the pointer onward. Register 0 is read-only
// from the bus and is loaded by the sensor stream.
module i2c_slave_oe
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR     = 7'h27,
    parameter int unsigned DATA_DEPTH     = 8,
    parameter int unsigned NREGS          = 16,
    parameter int unsigned REG_ADDR_BITS  = 4,
    parameter logic [7:0]  CONFIG_DEFAULT = 8'h00
) (
    input  logic           i_clk,
    input  logic           i_rst,
    i2c_slave_oe_if.slave  bus
);

    localparam int unsigned DW        = DATA_DEPTH;
    localparam logic [3:0]  BYTE_BITS = 4'd8;

    logic scl_rise, scl_fall, sda_sync, start_det, stop_det;

    state_e                   state_q, state_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]            shift_q, shift_d;
    logic [DW-1:0]            shadow_q, shadow_d;
    logic [REG_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [REG_ADDR_BITS-1:0] ptr_inc;
    logic                     rw_q, rw_d;
    logic                     sda_oe_q, sda_oe_d;
    logic                     busy_q, busy_d;
    logic                     wr_valid_q, wr_valid_d;
    wr_evt_t                  wr_q, wr_d;
    logic                     sensor_ready_q, sensor_ready_d;
    logic [DW-1:0]            regs_q [NREGS];
    logic [DW-1:0]            regs_d [NREGS];
    logic                     byte_done;

    i2c_line_sync u_sync (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .scl_in    (bus.i_scl_in),
        .sda_in    (bus.i_sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_sync  (sda_sync),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign ptr_inc   = ptr_q + REG_ADDR_BITS'(1);
    // Eight bits are in; the following SCL fall opens the ACK slot
    assign byte_done = scl_fall && (bit_cnt_q == BYTE_BITS);

    // Next-state, register file and SDA drive
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        shadow_d       = shadow_q;
        ptr_d          = ptr_q;
        rw_d           = rw_q;
        sda_oe_d       = sda_oe_q;
        busy_d         = busy_q;
        wr_valid_d     = 1'b0;
        wr_d           = wr_q;
        sensor_ready_d = 1'b1;
        regs_d         = regs_q;

        if (bus.i_sensor_valid) begin
            regs_d[0] = DW'(bus.i_sensor_bits);
        end

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && (bit_cnt_q != BYTE_BITS)) begin
                        shift_d   = {shift_q[DW-2:0], sda_sync};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        bit_cnt_d = '0;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[DW-1:1] == SLAVE_ADDR) begin
                                state_d  = ST_ADDR_ACK;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shift_q[0];
                            end else begin
                                state_d  = ST_IGNORE;
                                sda_oe_d = 1'b0;
                                busy_d   = 1'b0;
                            end
                        end else if (state_q == ST_PTR) begin
                            ptr_d    = shift_q[REG_ADDR_BITS-1:0];
                            state_d  = ST_PTR_ACK;
                            sda_oe_d = 1'b1;
                        end else begin
                            // Pointer 0 is still ACKed and reported, never stored
                            wr_valid_d  = 1'b1;
                            wr_d.addr   = REG_ADDR_W'(ptr_q);
                            wr_d.bits   = DATA_W'(shift_q);
                            if (ptr_q != '0) begin
                                regs_d[ptr_q] = shift_q;
                            end
                            ptr_d    = ptr_inc;
                            state_d  = ST_WDATA_ACK;
                            sda_oe_d = 1'b1;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            // First data bit goes out on the fall that ends ACK
                            shadow_d  = {regs_q[ptr_q][DW-2:0], 1'b0};
                            sda_oe_d  = ~regs_q[ptr_q][DW-1];
                            bit_cnt_d = 4'd1;
                            state_d   = ST_RDATA;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_PTR;
                        end
                    end
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_WDATA;
                    end
                end

                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == BYTE_BITS) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_RACK;
                        end else begin
                            sda_oe_d  = ~shadow_q[DW-1];
                            shadow_d  = {shadow_q[DW-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                ST_RACK: begin
                    // bit_cnt doubles as "ACK seen, next byte loaded"
                    if (scl_rise) begin
                        ptr_d = ptr_inc;
                        if (sda_sync == ACK) begin
                            shadow_d  = regs_q[ptr_inc];
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
                        sda_oe_d = ~shadow_q[DW-1];
                        shadow_d = {shadow_q[DW-2:0], 1'b0};
                        state_d  = ST_RDATA;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            shadow_q       <= '0;
            ptr_q          <= '0;
            rw_q           <= 1'b0;
            sda_oe_q       <= 1'b0;
            busy_q         <= 1'b0;
            wr_valid_q     <= 1'b0;
            wr_q           <= '0;
            sensor_ready_q <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == 0) ? '0 : CONFIG_DEFAULT;
            end
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            shadow_q       <= shadow_d;
            ptr_q          <= ptr_d;
            rw_q           <= rw_d;
            sda_oe_q       <= sda_oe_d;
            busy_q         <= busy_d;
            wr_valid_q     <= wr_valid_d;
            wr_q           <= wr_d;
            sensor_ready_q <= sensor_ready_d;
            regs_q         <= regs_d;
        end
    end

    assign bus.o_sda_oe       = sda_oe_q;
    assign bus.o_sda_out      = 1'b0;
    assign bus.o_busy         = busy_q;
    assign bus.o_wr_valid     = wr_valid_q;
    assign bus.o_wr_addr      = wr_q.addr;
    assign bus.o_wr_bits      = wr_q.bits;
    assign bus.o_sensor_ready = sensor_ready_q;

endmodule

// File: tb/tb_i2c_slave_oe.sv
// Bench for i2c_slave_oe: bit-banged I2C master on an open-drain SDA
// line, write-event monitor and expected-value queues.
module tb_i2c_slave_oe;
    import i2c_pkg::*;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   oe_cnt = 0;

    wr_evt_t got_wr [$];
    wr_evt_t exp_wr [$];
    bq_t     exp_rd;

    i2c_slave_oe_if bus ();

    assign bus.i_scl_in = m_scl;
    assign bus.i_sda_in = m_sda & ~bus.o_sda_oe;

    i2c_slave_oe dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        wr_evt_t ev;
        if (bus.o_sda_oe === 1'b1) oe_cnt++;
        if (bus.o_wr_valid === 1'b1) begin
            ev.addr = bus.o_wr_addr;
            ev.bits = bus.o_wr_bits;
            got_wr.push_back(ev);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period: drive b in the low phase, sample line and oe mid-high
    task automatic clk_bit(input logic b, output logic s, output logic oe);
        tick(5); m_sda = b;
        tick(5); m_scl = 1'b1;
        tick(5); s = bus.i_sda_in; oe = bus.o_sda_oe;
        tick(5); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (m_scl) begin
            m_sda = 1'b0; tick(10); m_scl = 1'b0;
        end else begin
            tick(5); m_sda = 1'b1;
            tick(5); m_scl = 1'b1;
            tick(10); m_sda = 1'b0;
            tick(10); m_scl = 1'b0;
        end
    endtask

    task automatic i2c_stop();
        tick(5); m_sda = 1'b0;
        tick(5); m_scl = 1'b1;
        tick(10); m_sda = 1'b1;
        tick(10);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s, oe;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s, oe);
        clk_bit(1'b1, ack, oe);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d, output logic oe_ack);
        logic s, oe;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s, oe);
            d = {d[6:0], s};
        end
        clk_bit(ack, s, oe_ack);
    endtask

    // Pointer + data write; expected write events are queued here
    task automatic wr_txn(input logic [7:0] ptr, input bq_t data, output logic nak_any);
        logic a;
        i2c_start();
        send_byte(8'h4E, a); nak_any = a;
        send_byte(ptr, a);   nak_any |= a;
        for (int i = 0; i < data.size(); i++) begin
            wr_evt_t ev;
            send_byte(data[i], a); nak_any |= a;
            ev.addr = 4'(ptr[3:0] + 4'(i));
            ev.bits = data[i];
            exp_wr.push_back(ev);
        end
        i2c_stop();
    endtask

    // Optional pointer set + repeated START, then n-byte read ending in NAK
    task automatic rd_txn(input logic [7:0] ptr, input int n, input logic set_ptr,
                          output bq_t d, output logic nak_any, output logic oe_nak);
        logic a;
        logic [7:0] b;
        d = {};
        nak_any = 1'b0;
        i2c_start();
        if (set_ptr) begin
            send_byte(8'h4E, a); nak_any |= a;
            send_byte(ptr, a);   nak_any |= a;
            i2c_start();
        end
        send_byte(8'h4F, a); nak_any |= a;
        for (int i = 0; i < n; i++) begin
            recv_byte((i == n - 1) ? NAK : ACK, b, oe_nak);
            d.push_back(b);
        end
        i2c_stop();
    endtask

    task automatic test_reset();
        tick(3);
        checks++; if (bus.o_sda_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b required 0", bus.o_sda_oe); end
        checks++; if (bus.o_wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid: got %b required 0", bus.o_wr_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", bus.o_busy); end
        checks++; if (bus.o_sensor_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", bus.o_sensor_ready); end
        rst = 1'b1;
        tick(1);
        checks++; if (bus.o_sensor_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b required 1", bus.o_sensor_ready); end
        tick(10);
    endtask

    task automatic test_write();
        bq_t q;
        logic nak, a;
        q.push_back(8'hA5);
        i2c_start();
        send_byte(8'h4E, a); nak = a;
        send_byte(8'h03, a); nak |= a;
        send_byte(q[0], a);  nak |= a;
        exp_wr.push_back('{addr: 4'd3, bits: 8'hA5});
        checks++; if (nak !== 1'b0) begin failures++; $display("FAIL write_acks: got nak=%b required 0", nak); end
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b required 1", bus.o_busy); end
        i2c_stop();
        tick(5);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL busy_after_stop: got %b required 0", bus.o_busy); end
        checks++; if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL write_count: got %0d required %0d", got_wr.size(), exp_wr.size()); end
    endtask

    task automatic test_combined_read();
        bq_t d;
        logic nak, oe_nak;
        exp_rd = {};
        exp_rd.push_back(8'hA5);
        rd_txn(8'h03, 1, 1'b1, d, nak, oe_nak);
        checks++; if (nak !== 1'b0) begin failures++; $display("FAIL read_acks: got nak=%b required 0", nak); end
        checks++; if (d[0] !== exp_rd[0]) begin failures++; $display("FAIL read_byte: got %02h required %02h", d[0], exp_rd[0]); end
        checks++; if (oe_nak !== 1'b0) begin failures++; $display("FAIL read_release: got oe=%b required 0", oe_nak); end
        checks++; if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL read_no_write: got %0d required %0d", got_wr.size(), exp_wr.size()); end
    endtask

    task automatic test_wrong_addr();
        bq_t d;
        logic a1, a2, nak, oe_nak;
        int oe0;
        oe0 = oe_cnt;
        i2c_start();
        send_byte(8'h50, a1);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL wrong_busy: got %b required 0", bus.o_busy); end
        send_byte(8'h11, a2);
        i2c_stop();
        checks++; if ({a1, a2} !== 2'b11) begin failures++; $display("FAIL wrong_acks: got %b required 11", {a1, a2}); end
        checks++; if (oe_cnt != oe0) begin failures++; $display("FAIL wrong_oe: got %0d oe cycles required 0", oe_cnt - oe0); end
        checks++; if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL wrong_no_write: got %0d required %0d", got_wr.size(), exp_wr.size()); end
        rd_txn(8'h03, 1, 1'b1, d, nak, oe_nak);
        checks++; if (d[0] !== 8'hA5) begin failures++; $display("FAIL wrong_reg_kept: got %02h required a5", d[0]); end
    endtask

    task automatic test_sensor_wrap();
        bq_t q, d;
        logic nak, oe_nak;
        bus.i_sensor_bits = 8'h19; bus.i_sensor_valid = 1'b1;
        tick(1);
        bus.i_sensor_valid = 1'b0;
        q.push_back(8'h5A);
        wr_txn(8'h01, q, nak);
        q = {};
        q.push_back(8'h3C);
        wr_txn(8'h0F, q, nak);
        checks++; if (nak !== 1'b0) begin failures++; $display("FAIL wrap_write_acks: got nak=%b required 0", nak); end
        exp_rd = {};
        exp_rd.push_back(8'h3C); exp_rd.push_back(8'h19);
        rd_txn(8'h0F, 2, 1'b1, d, nak, oe_nak);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (d[i] !== exp_rd[i]) begin failures++; $display("FAIL wrap_read%0d: got %02h required %02h", i, d[i], exp_rd[i]); end
        end
        // Pointer must now be 1, which holds 0x5A
        rd_txn(8'h00, 1, 1'b0, d, nak, oe_nak);
        checks++; if (d[0] !== 8'h5A) begin failures++; $display("FAIL wrap_ptr_end: got %02h required 5a", d[0]); end
        checks++; if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL wrap_write_count: got %0d required %0d", got_wr.size(), exp_wr.size()); end
    endtask

    task automatic test_read_only();
        bq_t q, d;
        logic nak, oe_nak;
        q.push_back(8'h77);
        wr_txn(8'h00, q, nak);
        checks++; if (nak !== 1'b0) begin failures++; $display("FAIL ro_acks: got nak=%b required 0", nak); end
        rd_txn(8'h00, 1, 1'b1, d, nak, oe_nak);
        checks++; if (d[0] !== 8'h19) begin failures++; $display("FAIL ro_reg0: got %02h required 19", d[0]); end
        checks++; if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL ro_write_count: got %0d required %0d", got_wr.size(), exp_wr.size()); end
    endtask

    task automatic test_back_to_back();
        bq_t q, d;
        logic nak, oe_nak;
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
        wr_txn(8'h05, q, nak);
        checks++; if (nak !== 1'b0) begin failures++; $display("FAIL b2b_acks: got nak=%b required 0", nak); end
        exp_rd = q;
        rd_txn(8'h05, 3, 1'b1, d, nak, oe_nak);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (d[i] !== exp_rd[i]) begin failures++; $display("FAIL b2b_read%0d: got %02h required %02h", i, d[i], exp_rd[i]); end
        end
    endtask

    task automatic test_write_log();
        checks++;
        if (got_wr.size() != exp_wr.size()) begin
            failures++; $display("FAIL wr_log_size: got %0d required %0d", got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            checks++;
            if (got_wr[i] !== exp_wr[i]) begin
                failures++;
                $display("FAIL wr_log%0d: got addr=%0d bits=%02h required addr=%0d bits=%02h",
                         i, got_wr[i].addr, got_wr[i].bits, exp_wr[i].addr, exp_wr[i].bits);
            end
        end
    endtask

    task automatic test_reset_mid();
        bq_t d;
        logic s, oe, nak, oe_nak;
        i2c_start();
        for (int i = 7; i >= 0; i--) clk_bit(((8'h4E >> i) & 8'h01) != 0, s, oe);
        tick(5);
        checks++; if (bus.o_sda_oe !== 1'b1) begin failures++; $display("FAIL mid_ack_driven: got %b required 1", bus.o_sda_oe); end
        rst = 1'b0;
        #1;
        checks++; if (bus.o_sda_oe !== 1'b0) begin failures++; $display("FAIL mid_async_oe: got %b required 0", bus.o_sda_oe); end
        m_sda = 1'b1; m_scl = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(10);
        exp_rd = {};
        exp_rd.push_back(8'h00);
        rd_txn(8'h00, 1, 1'b0, d, nak, oe_nak);
        checks++; if (d[0] !== exp_rd[0]) begin failures++; $display("FAIL mid_reg0_cleared: got %02h required %02h", d[0], exp_rd[0]); end
        rd_txn(8'h0F, 1, 1'b1, d, nak, oe_nak);
        checks++; if (d[0] !== 8'h00) begin failures++; $display("FAIL mid_reg15_default: got %02h required 00", d[0]); end
    endtask

    initial begin
        bus.i_sensor_bits  = '0;
        bus.i_sensor_valid = 1'b0;
        test_reset();
        test_write();
        test_combined_read();
        test_wrong_addr();
        test_sensor_wrap();
        test_read_only();
        test_back_to_back();
        test_write_log();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
